// File: rtl/mmwb_pipe_reg_if.sv
// MEM/WB pipeline bus: MEM-stage results in, registered WB fields and register-file write port out.
// The pipeline register drives the master side; the WB stage consumes the slave side.
interface mmwb_pipe_reg_if #(
  parameter int OPFUNC_W = 6,
  parameter int WORD_W   = 32
);
  logic [OPFUNC_W-1:0] mm_opfunc;
  logic [1:0]          mm_MemtoReg;
  logic                mm_RegWEN;
  logic                mm_equal;
  logic                mm_halt;
  logic [4:0]          mm_rd;
  logic [WORD_W-1:0]   mm_portB;
  logic [WORD_W-1:0]   mm_npc;
  logic [WORD_W-1:0]   mm_ALUOut;
  logic [WORD_W-1:0]   mm_load;

  logic [OPFUNC_W-1:0] wb_opfunc;
  logic [1:0]          wb_MemtoReg;
  logic                wb_RegWEN;
  logic                wb_equal;
  logic                wb_halt;
  logic [4:0]          wb_rd;
  logic [WORD_W-1:0]   wb_portB;
  logic [WORD_W-1:0]   wb_npc;
  logic [WORD_W-1:0]   wb_ALUOut;
  logic [WORD_W-1:0]   wb_load;

  logic                rf_WEN;
  logic [4:0]          rf_wsel;
  logic [WORD_W-1:0]   rf_wdat;

  modport master (
    input  mm_opfunc, mm_MemtoReg, mm_RegWEN, mm_equal, mm_halt, mm_rd,
           mm_portB, mm_npc, mm_ALUOut, mm_load,
    output wb_opfunc, wb_MemtoReg, wb_RegWEN, wb_equal, wb_halt, wb_rd,
           wb_portB, wb_npc, wb_ALUOut, wb_load,
           rf_WEN, rf_wsel, rf_wdat
  );

  modport slave (
    output mm_opfunc, mm_MemtoReg, mm_RegWEN, mm_equal, mm_halt, mm_rd,
           mm_portB, mm_npc, mm_ALUOut, mm_load,
    input  wb_opfunc, wb_MemtoReg, wb_RegWEN, wb_equal, wb_halt, wb_rd,
           wb_portB, wb_npc, wb_ALUOut, wb_load,
           rf_WEN, rf_wsel, rf_wdat
  );
endinterface

// File: rtl/mmwb_pipe_reg.sv
// MEM/WB pipeline register with a one-entry load holding buffer, sticky halt and RF write port.
// Define MMWB_PERF_EN to add the 32-bit 'retired' instruction counter output.
module mmwb_pipe_reg #(
  parameter int OPFUNC_W = 6,
  parameter int WORD_W   = 32
) (
  input  logic CLK,
  input  logic nRST,
  input  logic ihit,
  input  logic dhit,
  input  logic mm_memop,
  input  logic flush,
  output logic advance,
`ifdef MMWB_PERF_EN
  output logic [31:0] retired,
`endif
  mmwb_pipe_reg_if.master bus
);

  typedef struct packed {
    logic [OPFUNC_W-1:0] opfunc;
    logic [1:0]          memtoreg;
    logic                regwen;
    logic                equal;
    logic                halt;
    logic [4:0]          rd;
    logic [WORD_W-1:0]   portb;
    logic [WORD_W-1:0]   npc;
    logic [WORD_W-1:0]   aluout;
    logic [WORD_W-1:0]   load;
  } wb_t;

  typedef enum logic {EMPTY, HELD} hold_state_t;

  wb_t               wb_q, wb_d;
  hold_state_t       state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_v;

`ifdef MMWB_PERF_EN
  logic [31:0] retired_q, retired_d;
`endif

  // A stalled load may complete early; the buffer lets the pipe advance later without a new dhit.
  always_comb begin
    hold_v  = (state_q == HELD);
    advance = ihit & (~mm_memop | dhit | hold_v) & ~wb_q.halt;
  end

  always_comb begin
    wb_d    = wb_q;
    state_d = state_q;
    hold_d  = hold_q;
    if (advance) begin
      state_d = EMPTY;
      if (flush) begin
        wb_d = '0;
      end else begin
        wb_d.opfunc   = bus.mm_opfunc;
        wb_d.memtoreg = bus.mm_MemtoReg;
        wb_d.regwen   = bus.mm_RegWEN;
        wb_d.equal    = bus.mm_equal;
        wb_d.halt     = bus.mm_halt;
        wb_d.rd       = bus.mm_rd;
        wb_d.portb    = bus.mm_portB;
        wb_d.npc      = bus.mm_npc;
        wb_d.aluout   = bus.mm_ALUOut;
        wb_d.load     = hold_v ? hold_q : bus.mm_load;
      end
    end else if ((state_q == EMPTY) && dhit && mm_memop && !wb_q.halt) begin
      hold_d  = bus.mm_load;
      state_d = HELD;
    end
  end

`ifdef MMWB_PERF_EN
  always_comb begin
    retired_d = retired_q;
    if (advance && !flush && (bus.mm_opfunc != '0)) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_q    <= '0;
      state_q <= EMPTY;
      hold_q  <= '0;
    end else begin
      wb_q    <= wb_d;
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.wb_opfunc   = wb_q.opfunc;
  assign bus.wb_MemtoReg = wb_q.memtoreg;
  assign bus.wb_RegWEN   = wb_q.regwen;
  assign bus.wb_equal    = wb_q.equal;
  assign bus.wb_halt     = wb_q.halt;
  assign bus.wb_rd       = wb_q.rd;
  assign bus.wb_portB    = wb_q.portb;
  assign bus.wb_npc      = wb_q.npc;
  assign bus.wb_ALUOut   = wb_q.aluout;
  assign bus.wb_load     = wb_q.load;

  // Writes to r0 are suppressed; 10 selects the link address for jal, 11 the lui immediate.
  always_comb begin
    bus.rf_WEN  = wb_q.regwen & (wb_q.rd != 5'd0);
    bus.rf_wsel = wb_q.rd;
    bus.rf_wdat = wb_q.aluout;
    case (wb_q.memtoreg)
      2'b01:   bus.rf_wdat = wb_q.load;
      2'b10:   bus.rf_wdat = wb_q.npc;
      2'b11:   bus.rf_wdat = wb_q.portb;
      default: bus.rf_wdat = wb_q.aluout;
    endcase
  end

endmodule

// File: tb/tb_mmwb_pipe_reg.sv
// Self-checking bench for mmwb_pipe_reg: directed scenarios plus randomized traffic against a queue-based model.
// Define MMWB_PERF_EN to also exercise the retired counter.
module tb_mmwb_pipe_reg;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, mm_memop, flush;
  logic advance;
`ifdef MMWB_PERF_EN
  logic [31:0] retired;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  mmwb_pipe_reg_if #(.OPFUNC_W(6), .WORD_W(32)) bus ();

  mmwb_pipe_reg #(.OPFUNC_W(6), .WORD_W(32)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .ihit     (ihit),
    .dhit     (dhit),
    .mm_memop (mm_memop),
    .flush    (flush),
    .advance  (advance),
`ifdef MMWB_PERF_EN
    .retired  (retired),
`endif
    .bus      (bus.master)
  );

  always #5 CLK = ~CLK;

  // Reference model state: what WB should show, plus a queue holding at most one early load.
  logic [5:0]  e_op;
  logic [1:0]  e_m2r;
  logic        e_wen, e_eq, e_halt;
  logic [4:0]  e_rd;
  logic [31:0] e_portb, e_npc, e_alu, e_load;
  logic [31:0] held[$];
  logic [31:0] e_ret;

  function automatic logic model_adv();
    return ihit && (!mm_memop || dhit || (held.size() != 0)) && !e_halt;
  endfunction

  function automatic logic [31:0] exp_wdat();
    case (e_m2r)
      2'd0:    return e_alu;
      2'd1:    return e_load;
      2'd2:    return e_npc;
      default: return e_portb;
    endcase
  endfunction

  function automatic logic [143:0] exp_vec();
    return {e_op, e_m2r, e_wen, e_eq, e_halt, e_rd, e_portb, e_npc, e_alu, e_load};
  endfunction

  function automatic logic [143:0] dut_vec();
    return {bus.wb_opfunc, bus.wb_MemtoReg, bus.wb_RegWEN, bus.wb_equal, bus.wb_halt,
            bus.wb_rd, bus.wb_portB, bus.wb_npc, bus.wb_ALUOut, bus.wb_load};
  endfunction

  task automatic model_reset();
    {e_op, e_m2r, e_wen, e_eq, e_halt, e_rd, e_portb, e_npc, e_alu, e_load} = '0;
    held.delete();
    e_ret = '0;
  endtask

  task automatic idle_inputs();
    ihit = 0; dhit = 0; mm_memop = 0; flush = 0;
    bus.mm_opfunc = '0; bus.mm_MemtoReg = '0; bus.mm_RegWEN = 0; bus.mm_equal = 0;
    bus.mm_halt = 0; bus.mm_rd = '0; bus.mm_portB = '0; bus.mm_npc = '0;
    bus.mm_ALUOut = '0; bus.mm_load = '0;
  endtask

  task automatic rand_mm();
    bus.mm_opfunc   = 6'($urandom_range(0, 63));
    bus.mm_MemtoReg = 2'($urandom_range(0, 3));
    bus.mm_RegWEN   = 1'($urandom_range(0, 1));
    bus.mm_equal    = 1'($urandom_range(0, 1));
    bus.mm_halt     = 1'b0;
    bus.mm_rd       = 5'($urandom_range(0, 31));
    bus.mm_portB    = $urandom;
    bus.mm_npc      = $urandom;
    bus.mm_ALUOut   = $urandom;
    bus.mm_load     = $urandom;
  endtask

  // One clock: model consumes the current inputs at the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    logic a;
    a = model_adv();
    @(posedge CLK);
    if (a) begin
      if (flush) begin
        {e_op, e_m2r, e_wen, e_eq, e_halt, e_rd, e_portb, e_npc, e_alu, e_load} = '0;
      end else begin
        e_op = bus.mm_opfunc; e_m2r = bus.mm_MemtoReg; e_wen = bus.mm_RegWEN;
        e_eq = bus.mm_equal; e_halt = bus.mm_halt; e_rd = bus.mm_rd;
        e_portb = bus.mm_portB; e_npc = bus.mm_npc; e_alu = bus.mm_ALUOut;
        e_load = (held.size() != 0) ? held[0] : bus.mm_load;
        if (bus.mm_opfunc != 0) e_ret = e_ret + 32'd1;
      end
      held.delete();
    end else if (!e_halt && dhit && mm_memop && (held.size() == 0)) begin
      held.push_back(bus.mm_load);
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 0;
    model_reset();
    @(negedge CLK);
    nRST = 1;
  endtask

  task automatic test_reset();
    nRST = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge CLK);
    n_compared++;
    if (dut_vec() !== 144'd0) begin
      n_mismatched++; $display("[TB] FAIL reset_wb: got %h expected 0", dut_vec());
    end
    n_compared++;
    if ({bus.rf_WEN, bus.rf_wsel, bus.rf_wdat} !== 38'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_rf: got wen=%b wsel=%0d wdat=%h expected all 0", bus.rf_WEN, bus.rf_wsel, bus.rf_wdat);
    end
    nRST = 1;
  endtask

  task automatic test_alu_write();
    idle_inputs();
    bus.mm_opfunc = 6'h20; bus.mm_RegWEN = 1; bus.mm_rd = 5'd5;
    bus.mm_ALUOut = 32'h1234; bus.mm_load = 32'h9999; ihit = 1;
    #1;
    n_compared++;
    if (advance !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL alu_advance: got %b expected 1", advance);
    end
    tick();
    n_compared++;
    if ({bus.rf_WEN, bus.rf_wsel, bus.rf_wdat} !== {1'b1, 5'd5, 32'h1234}) begin
      n_mismatched++;
      $display("[TB] FAIL alu_write: got wen=%b wsel=%0d wdat=%h expected wen=1 wsel=5 wdat=00001234",
               bus.rf_WEN, bus.rf_wsel, bus.rf_wdat);
    end
    idle_inputs();
  endtask

  task automatic test_load_hold();
    idle_inputs();
    bus.mm_opfunc = 6'h23; bus.mm_MemtoReg = 2'b01; bus.mm_RegWEN = 1; bus.mm_rd = 5'd9;
    mm_memop = 1; dhit = 1; bus.mm_load = 32'hCAFEF00D;
    #1;
    n_compared++;
    if (advance !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL load_stall_adv: got %b expected 0", advance);
    end
    tick();
    dhit = 0; bus.mm_load = 32'h11111111;
    tick();
    dhit = 1; bus.mm_load = 32'h22222222;
    tick();
    dhit = 0; ihit = 1; bus.mm_load = 32'hDEADBEEF;
    #1;
    n_compared++;
    if (advance !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL held_adv: got %b expected 1", advance);
    end
    tick();
    n_compared++;
    if ({bus.wb_load, bus.rf_wdat} !== {32'hCAFEF00D, 32'hCAFEF00D}) begin
      n_mismatched++;
      $display("[TB] FAIL held_load: got wb_load=%h rf_wdat=%h expected CAFEF00D", bus.wb_load, bus.rf_wdat);
    end
    dhit = 1; bus.mm_load = 32'h5555AAAA;
    tick();
    n_compared++;
    if (bus.wb_load !== 32'h5555AAAA) begin
      n_mismatched++; $display("[TB] FAIL live_load: got %h expected 5555AAAA", bus.wb_load);
    end
    dhit = 0;
    #1;
    n_compared++;
    if (advance !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL buffer_untouched: got advance=%b expected 0", advance);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    logic [143:0] saved;
    idle_inputs();
    bus.mm_opfunc = 6'h11; bus.mm_RegWEN = 1; bus.mm_rd = 5'd7; bus.mm_ALUOut = 32'hABCD;
    ihit = 1; flush = 1;
    tick();
    n_compared++;
    if ({bus.wb_opfunc, bus.rf_WEN} !== 7'd0 || dut_vec() !== 144'd0) begin
      n_mismatched++;
      $display("[TB] FAIL flush_bubble: got op=%h wen=%b wb=%h expected all 0", bus.wb_opfunc, bus.rf_WEN, dut_vec());
    end
    flush = 0; bus.mm_opfunc = 6'h12; bus.mm_rd = 5'd3;
    tick();
    saved = dut_vec();
    ihit = 0; flush = 1; rand_mm();
    tick();
    n_compared++;
    if (dut_vec() !== exp_vec() || dut_vec() !== saved) begin
      n_mismatched++; $display("[TB] FAIL flush_no_adv: got %h expected %h", dut_vec(), exp_vec());
    end
    flush = 0; mm_memop = 1; dhit = 1; bus.mm_load = 32'h0BADF00D;
    tick();
    ihit = 1; flush = 1; dhit = 0;
    tick();
    flush = 0;
    #1;
    n_compared++;
    if (advance !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL flush_clears_held: got advance=%b expected 0", advance);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic a;
    for (int i = 0; i < 400; i++) begin
      rand_mm();
      ihit     = ($urandom_range(0, 3) != 0);
      dhit     = ($urandom_range(0, 2) == 0);
      mm_memop = ($urandom_range(0, 1) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      #1;
      a = model_adv();
      n_compared++;
      if (advance !== a) begin
        n_mismatched++; $display("[TB] FAIL rand_adv[%0d]: got %b expected %b", i, advance, a);
      end
      tick();
      n_compared++;
      if (dut_vec() !== exp_vec()) begin
        n_mismatched++; $display("[TB] FAIL rand_wb[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
      n_compared++;
      if ({bus.rf_WEN, bus.rf_wsel, bus.rf_wdat} !== {e_wen && (e_rd != 0), e_rd, exp_wdat()}) begin
        n_mismatched++;
        $display("[TB] FAIL rand_rf[%0d]: got %b/%0d/%h expected %b/%0d/%h", i, bus.rf_WEN, bus.rf_wsel,
                 bus.rf_wdat, e_wen && (e_rd != 0), e_rd, exp_wdat());
      end
`ifdef MMWB_PERF_EN
      n_compared++;
      if (retired !== e_ret) begin
        n_mismatched++; $display("[TB] FAIL rand_retired[%0d]: got %0d expected %0d", i, retired, e_ret);
      end
`endif
    end
    idle_inputs();
  endtask

  task automatic test_halt();
    logic [143:0] saved;
    idle_inputs();
    bus.mm_opfunc = 6'h3F; bus.mm_halt = 1; ihit = 1;
    tick();
    n_compared++;
    if (bus.wb_halt !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL halt_set: got %b expected 1", bus.wb_halt);
    end
    saved = dut_vec();
    for (int i = 0; i < 6; i++) begin
      rand_mm();
      ihit = 1; dhit = 1'($urandom_range(0, 1)); mm_memop = 1'($urandom_range(0, 1));
      #1;
      n_compared++;
      if (advance !== 1'b0) begin
        n_mismatched++; $display("[TB] FAIL halt_adv[%0d]: got %b expected 0", i, advance);
      end
      tick();
      n_compared++;
      if (dut_vec() !== saved) begin
        n_mismatched++; $display("[TB] FAIL halt_frozen[%0d]: got %h expected %h", i, dut_vec(), saved);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle_inputs();
    bus.mm_opfunc = 6'h05; bus.mm_RegWEN = 1; bus.mm_rd = 5'd12; bus.mm_ALUOut = 32'h77; ihit = 1;
    tick();
    ihit = 0; mm_memop = 1; dhit = 1; bus.mm_load = 32'hFEEDFACE;
    tick();
    #2;
    nRST = 0;
    model_reset();
    #1;
    n_compared++;
    if (dut_vec() !== 144'd0 || {bus.rf_WEN, bus.rf_wsel, bus.rf_wdat} !== 38'd0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: got wb=%h wen=%b wsel=%0d wdat=%h expected all 0",
               dut_vec(), bus.rf_WEN, bus.rf_wsel, bus.rf_wdat);
    end
    @(negedge CLK);
    nRST = 1;
    ihit = 1; dhit = 0; mm_memop = 1;
    #1;
    n_compared++;
    if (advance !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_discards_held: got advance=%b expected 0", advance);
    end
    dhit = 1; bus.mm_load = 32'h13579BDF;
    tick();
    n_compared++;
    if (bus.wb_load !== 32'h13579BDF) begin
      n_mismatched++; $display("[TB] FAIL post_reset_load: got %h expected 13579BDF", bus.wb_load);
    end
    idle_inputs();
  endtask

`ifdef MMWB_PERF_EN
  task automatic test_perf();
    do_reset();
    idle_inputs();
    ihit = 1;
    for (int i = 0; i < 3; i++) begin
      bus.mm_opfunc = 6'(i + 1);
      tick();
    end
    flush = 1;
    tick();
    flush = 0; bus.mm_opfunc = 6'h00;
    tick();
    n_compared++;
    if (retired !== 32'd3) begin
      n_mismatched++; $display("[TB] FAIL perf_count: got %0d expected 3", retired);
    end
    ihit = 0;
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    e_ret = 32'hFFFFFFFF;
    ihit = 1; bus.mm_opfunc = 6'h01;
    tick();
    n_compared++;
    if (retired !== 32'd0) begin
      n_mismatched++; $display("[TB] FAIL perf_wrap: got %h expected 0", retired);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_write();
    test_load_hold();
    test_flush();
    test_random();
    test_halt();
    test_reset_mid();
`ifdef MMWB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
